tlc_phase_scheduler: RTL and testbench



---
 rtl/tlc_pkg.sv | 24 ++
 rtl/tlc_rr_pick.sv | 37 +++
 rtl/tlc_phase_scheduler.sv | 169 ++++++++++++++++
 tb/tb_tlc_phase_scheduler.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared definitions for the demand-actuated intersection scheduler:
// lamp encodings, approach codes and controller phase codes.
package tlc_pkg;

  localparam logic [2:0] LIGHT_RED    = 3'b100;
  localparam logic [2:0] LIGHT_YELLOW = 3'b010;
  localparam logic [2:0] LIGHT_GREEN  = 3'b001;

  localparam logic [1:0] DIR_N = 2'd0;
  localparam logic [1:0] DIR_E = 2'd1;
  localparam logic [1:0] DIR_S = 2'd2;
  localparam logic [1:0] DIR_W = 2'd3;

  typedef enum logic [1:0] {
    PH_ALLRED = 2'd0,
    PH_GREEN  = 2'd1,
    PH_YELLOW = 2'd2
  } phase_e;

  function automatic logic [3:0] dir_onehot(input logic [1:0] d);
    return 4'b0001 << d;
  endfunction

endpackage

// File: rtl/tlc_rr_pick.sv
// Rotating-priority picker: first set request bit searching last+1, last+2,
// last+3, last (mod 4). grant_dir holds last when nothing is requested.
module tlc_rr_pick
  import tlc_pkg::*;
(
  input  logic [3:0] req,
  input  logic [1:0] last,
  output logic [1:0] grant_dir,
  output logic       any
);

  logic [1:0] w_cand [4];
  logic [3:0] w_hit;

  // Candidate gi is the approach gi+1 steps after last; step 4 wraps to last.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
      assign w_cand[gi] = last + 2'(gi + 1);
      assign w_hit[gi]  = req[w_cand[gi]];
    end
  endgenerate

  always_comb begin
    grant_dir = last;
    if (w_hit[0])
      grant_dir = w_cand[0];
    else if (w_hit[1])
      grant_dir = w_cand[1];
    else if (w_hit[2])
      grant_dir = w_cand[2];
    else if (w_hit[3])
      grant_dir = w_cand[3];
  end

  assign any = |req;

endmodule

// File: rtl/tlc_phase_scheduler.sv
// Demand-actuated four-approach phase scheduler: latches car/ped requests,
// serves one approach at a time with min/max green, clearance, walk and pre-emption.
module tlc_phase_scheduler
  import tlc_pkg::*;
#(
  parameter int GREEN_MIN = 4,
  parameter int GREEN_MAX = 10,
  parameter int YELLOW_T  = 3,
  parameter int ALLRED_T  = 2,
  parameter int WALK_T    = 3
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] car_req,
  input  logic [3:0] ped_req,
  input  logic       emerg_req,
  input  logic [1:0] emerg_dir,
  output logic [2:0] north_light,
  output logic [2:0] east_light,
  output logic [2:0] south_light,
  output logic [2:0] west_light,
  output logic [3:0] ped_walk,
  output logic [1:0] phase,
  output logic [1:0] active_dir
);

  localparam logic [7:0] C_GMIN_LAST   = 8'(GREEN_MIN - 1);
  localparam logic [7:0] C_GMAX_LAST   = 8'(GREEN_MAX - 1);
  localparam logic [7:0] C_YELLOW_LAST = 8'(YELLOW_T - 1);
  localparam logic [7:0] C_ALLRED_LAST = 8'(ALLRED_T - 1);
  localparam logic [7:0] C_WALK        = 8'(WALK_T);

  phase_e     r_phase,   w_phase_next;
  logic [1:0] r_dir,     w_dir_next;
  logic [7:0] r_cnt,     w_cnt_next;
  logic [3:0] r_pending, w_pending_next;
  logic [3:0] r_ped_flag, w_ped_flag_next;
  logic       r_walk,    w_walk_next;

  logic [3:0] w_dir_mask;
  logic [3:0] w_req_mask;
  logic [3:0] w_pending_lat;
  logic [3:0] w_ped_lat;
  logic [3:0] w_others;
  logic [1:0] w_rr_dir;
  logic       w_rr_any;
  logic       w_gap_out;
  logic       w_max_out;

  // The approach holding green never latches its own requests.
  assign w_dir_mask    = dir_onehot(r_dir);
  assign w_req_mask    = (r_phase == PH_GREEN) ? ~w_dir_mask : 4'hF;
  assign w_pending_lat = r_pending | ((car_req | ped_req) & w_req_mask);
  assign w_ped_lat     = r_ped_flag | (ped_req & w_req_mask);
  assign w_others      = r_pending & ~w_dir_mask;

  assign w_gap_out = (r_cnt >= C_GMIN_LAST) && (w_others != 4'd0) && !car_req[r_dir];
  assign w_max_out = (r_cnt == C_GMAX_LAST) && (w_others != 4'd0);

  tlc_rr_pick u_pick (
    .req       (r_pending),
    .last      (r_dir),
    .grant_dir (w_rr_dir),
    .any       (w_rr_any)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_phase    <= PH_ALLRED;
      r_dir      <= DIR_W;
      r_cnt      <= 8'd0;
      r_pending  <= 4'd0;
      r_ped_flag <= 4'd0;
      r_walk     <= 1'b0;
    end else begin
      r_phase    <= w_phase_next;
      r_dir      <= w_dir_next;
      r_cnt      <= w_cnt_next;
      r_pending  <= w_pending_next;
      r_ped_flag <= w_ped_flag_next;
      r_walk     <= w_walk_next;
    end
  end

  always_comb begin
    w_phase_next    = r_phase;
    w_dir_next      = r_dir;
    w_cnt_next      = r_cnt;
    w_pending_next  = w_pending_lat;
    w_ped_flag_next = w_ped_lat;
    w_walk_next     = r_walk;
    case (r_phase)
      PH_ALLRED: begin
        if (r_cnt != C_ALLRED_LAST) begin
          w_cnt_next = r_cnt + 8'd1;
        end else if (emerg_req) begin
          // Emergency grants leave the ped flag set for the next normal service.
          w_phase_next   = PH_GREEN;
          w_dir_next     = emerg_dir;
          w_cnt_next     = 8'd0;
          w_pending_next = w_pending_lat & ~dir_onehot(emerg_dir);
          w_walk_next    = 1'b0;
        end else if (w_rr_any) begin
          w_phase_next    = PH_GREEN;
          w_dir_next      = w_rr_dir;
          w_cnt_next      = 8'd0;
          w_pending_next  = w_pending_lat & ~dir_onehot(w_rr_dir);
          w_walk_next     = w_ped_lat[w_rr_dir];
          w_ped_flag_next = w_ped_lat & ~dir_onehot(w_rr_dir);
        end
      end
      PH_GREEN: begin
        if (r_cnt != C_GMAX_LAST)
          w_cnt_next = r_cnt + 8'd1;
        if (emerg_req && (emerg_dir != r_dir)) begin
          w_phase_next = PH_YELLOW;
          w_cnt_next   = 8'd0;
        end else if (!emerg_req && (w_gap_out || w_max_out)) begin
          w_phase_next = PH_YELLOW;
          w_cnt_next   = 8'd0;
        end
      end
      PH_YELLOW: begin
        if (r_cnt == C_YELLOW_LAST) begin
          w_phase_next = PH_ALLRED;
          w_cnt_next   = 8'd0;
        end else begin
          w_cnt_next = r_cnt + 8'd1;
        end
      end
      default: begin
        w_phase_next = PH_ALLRED;
        w_cnt_next   = 8'd0;
      end
    endcase
  end

  logic [2:0] w_active_lamp;
  logic       w_walk_on;
  logic [2:0] w_lamp [4];

  always_comb begin
    w_active_lamp = LIGHT_RED;
    w_walk_on     = 1'b0;
    case (r_phase)
      PH_GREEN: begin
        w_active_lamp = LIGHT_GREEN;
        w_walk_on     = r_walk && (r_cnt < C_WALK);
      end
      PH_YELLOW: w_active_lamp = LIGHT_YELLOW;
      default:   w_active_lamp = LIGHT_RED;
    endcase
  end

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lamp
      assign w_lamp[gi]   = (r_dir == 2'(gi)) ? w_active_lamp : LIGHT_RED;
      assign ped_walk[gi] = (r_dir == 2'(gi)) && w_walk_on;
    end
  endgenerate

  assign north_light = w_lamp[DIR_N];
  assign east_light  = w_lamp[DIR_E];
  assign south_light = w_lamp[DIR_S];
  assign west_light  = w_lamp[DIR_W];
  assign phase       = r_phase;
  assign active_dir  = r_dir;

endmodule

// File: tb/tb_tlc_phase_scheduler.sv
// Directed bench for tlc_phase_scheduler: hand-sequenced requests, every
// output checked each cycle against hand-derived phase/approach/walk values.
module tb_tlc_phase_scheduler;
  import tlc_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] car_req = 4'd0;
  logic [3:0] ped_req = 4'd0;
  logic       emerg_req = 1'b0;
  logic [1:0] emerg_dir = 2'd0;
  logic [2:0] north_light, east_light, south_light, west_light;
  logic [3:0] ped_walk;
  logic [1:0] phase, active_dir;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [1:0] AR = 2'd0;
  localparam logic [1:0] G  = 2'd1;
  localparam logic [1:0] Y  = 2'd2;

  always #5 clk = ~clk;

  tlc_phase_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .car_req     (car_req),
    .ped_req     (ped_req),
    .emerg_req   (emerg_req),
    .emerg_dir   (emerg_dir),
    .north_light (north_light),
    .east_light  (east_light),
    .south_light (south_light),
    .west_light  (west_light),
    .ped_walk    (ped_walk),
    .phase       (phase),
    .active_dir  (active_dir)
  );

  function automatic logic [11:0] exp_lamps(input logic [1:0] ph, input logic [1:0] d);
    logic [11:0] v;
    logic [2:0]  on;
    int          k;
    on = (ph == G) ? 3'b001 : ((ph == Y) ? 3'b010 : 3'b100);
    v  = {4{3'b100}};
    k  = 3 - int'(d);
    v[k*3 +: 3] = on;
    return v;
  endfunction

  task automatic check(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_now(input string tag, input logic [1:0] ph, input logic [1:0] d,
                         input logic [3:0] walk);
    $display("t=%0t %s ph=%0d dir=%0d lamps=%03b_%03b_%03b_%03b walk=%b",
             $time, tag, phase, active_dir, north_light, east_light, south_light,
             west_light, ped_walk);
    check({tag, ".lamps"}, {north_light, east_light, south_light, west_light},
          exp_lamps(ph, d));
    check({tag, ".walk"}, 12'(ped_walk), 12'(walk));
    check({tag, ".phase"}, 12'(phase), 12'(ph));
    check({tag, ".dir"}, 12'(active_dir), 12'(d));
  endtask

  task automatic cyc(input string tag, input logic [1:0] ph, input logic [1:0] d,
                     input logic [3:0] walk);
    @(negedge clk);
    chk_now(tag, ph, d, walk);
  endtask

  // Yellow for 3 cycles then 2 all-red cycles, approach d still reported.
  task automatic clear_seq(input string tag, input logic [1:0] d);
    repeat (3) cyc({tag, ".yel"}, Y, d, 4'b0000);
    repeat (2) cyc({tag, ".ar"}, AR, d, 4'b0000);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    @(negedge clk);
    chk_now("reset", AR, DIR_W, 4'b0000);
    rst = 1'b0;
    repeat (20) cyc("idle", AR, DIR_W, 4'b0000);

    // Single E pulse: green two cycles later.
    car_req = 4'b0010;
    cyc("e_latch", AR, DIR_W, 4'b0000);
    car_req = 4'b0000;
    cyc("e_green", G, DIR_E, 4'b0000);

    // E held, W pulsed: E max-out at 10 cycles, then W.
    car_req = 4'b1010;
    cyc("e_max", G, DIR_E, 4'b0000);
    car_req = 4'b0010;
    repeat (8) cyc("e_max", G, DIR_E, 4'b0000);
    clear_seq("e_max", DIR_E);
    cyc("w_after_max", G, DIR_W, 4'b0000);
    car_req = 4'b0000;
    repeat (3) cyc("w_gap", G, DIR_W, 4'b0000);
    clear_seq("w_gap", DIR_W);

    // E served again (latched during E clearance); S pulse gaps E out at 4 cycles.
    cyc("e_gap", G, DIR_E, 4'b0000);
    car_req = 4'b0100;
    cyc("e_gap", G, DIR_E, 4'b0000);
    car_req = 4'b0000;
    repeat (2) cyc("e_gap", G, DIR_E, 4'b0000);
    clear_seq("e_gap", DIR_E);
    repeat (15) cyc("s_rest", G, DIR_S, 4'b0000);

    // Move service to W, then load all four requests during W yellow.
    car_req = 4'b1000;
    cyc("s_rest", G, DIR_S, 4'b0000);
    car_req = 4'b0000;
    clear_seq("s_to_w", DIR_S);
    repeat (5) cyc("w_rest", G, DIR_W, 4'b0000);
    car_req = 4'b0001;
    cyc("w_rest", G, DIR_W, 4'b0000);
    car_req = 4'b0000;
    cyc("w_yel", Y, DIR_W, 4'b0000);
    car_req = 4'b1111;
    cyc("w_yel", Y, DIR_W, 4'b0000);
    car_req = 4'b0000;
    cyc("w_yel", Y, DIR_W, 4'b0000);
    repeat (2) cyc("w_ar", AR, DIR_W, 4'b0000);

    // Round robin N, E, S, W.
    repeat (4) cyc("rr_n", G, DIR_N, 4'b0000);
    clear_seq("rr_n", DIR_N);
    repeat (4) cyc("rr_e", G, DIR_E, 4'b0000);
    clear_seq("rr_e", DIR_E);
    repeat (4) cyc("rr_s", G, DIR_S, 4'b0000);
    clear_seq("rr_s", DIR_S);
    repeat (4) cyc("rr_w", G, DIR_W, 4'b0000);

    // Pedestrian S: walk for exactly 3 cycles of S green.
    ped_req = 4'b0100;
    cyc("ped_s", G, DIR_W, 4'b0000);
    ped_req = 4'b0000;
    clear_seq("ped_s", DIR_W);
    repeat (3) cyc("walk_s", G, DIR_S, 4'b0100);
    repeat (3) cyc("walk_off", G, DIR_S, 4'b0000);

    // Emergency for S while N green at cnt=1.
    car_req = 4'b0001;
    cyc("s_to_n", G, DIR_S, 4'b0000);
    car_req = 4'b0000;
    clear_seq("s_to_n", DIR_S);
    cyc("n_cnt0", G, DIR_N, 4'b0000);
    ped_req = 4'b0100;
    cyc("n_cnt1", G, DIR_N, 4'b0000);
    ped_req = 4'b0000;
    emerg_req = 1'b1;
    emerg_dir = DIR_S;
    clear_seq("preempt", DIR_N);
    cyc("em_hold", G, DIR_S, 4'b0000);
    car_req = 4'b0010;
    cyc("em_hold", G, DIR_S, 4'b0000);
    car_req = 4'b0000;
    repeat (13) cyc("em_hold", G, DIR_S, 4'b0000);
    emerg_req = 1'b0;
    clear_seq("em_release", DIR_S);
    repeat (5) cyc("e_normal", G, DIR_E, 4'b0000);

    // Ped flag for S survived the emergency grant.
    car_req = 4'b0100;
    cyc("e_normal", G, DIR_E, 4'b0000);
    car_req = 4'b0000;
    clear_seq("e_to_s", DIR_E);
    repeat (3) cyc("walk_kept", G, DIR_S, 4'b0100);
    repeat (2) cyc("walk_kept_off", G, DIR_S, 4'b0000);

    // Reset asserted mid-yellow with requests pending.
    car_req = 4'b1001;
    cyc("pre_rst", G, DIR_S, 4'b0000);
    car_req = 4'b0000;
    cyc("pre_rst", Y, DIR_S, 4'b0000);
    cyc("pre_rst", Y, DIR_S, 4'b0000);
    rst = 1'b1;
    #1;
    chk_now("rst_async", AR, DIR_W, 4'b0000);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) cyc("post_rst", AR, DIR_W, 4'b0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
